axis_seg_serializer_ctrl: RTL and testbench

//  Dequeue sequencer for the per-segment shift FIFO: drives each lane's tready in segment order
//  0..NUM_SEGMENTS-1, one segment per cycle, and emits a single segment-wide AXI Stream.

---
 rtl/axis_seg_serializer_ctrl.sv | 104 ++++++++++
 tb/tb_axis_seg_serializer_ctrl.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_seg_serializer_ctrl.sv
// axis_seg_serializer_ctrl: pops the lanes of a segmented beat in order 0..N-1 (one lane per cycle)
//   and serializes them onto one segment-wide AXI Stream; null segments are dropped and counted.
// Latency: 1 cycle from lane pop to out_tvalid; sustains 1 segment/cycle with out_tready high.
// Backpressure: out_tready low freezes the output register and blocks pops of emitting segments;
//   null segments are still discarded while the output is blocked.
//
// Ports:
//   aclk, aresetn      clock (rising edge) and asynchronous active-low reset
//   seg_in_tdata/tkeep per-lane head data/keep (unpacked, one entry per lane)
//   seg_in_tuser/tlast head tuser/tlast of the last lane (describe the whole beat)
//   seg_in_tvalid      per-lane non-empty flags
//   seg_in_tready      per-lane pop strobe, one-hot or zero
//   out_t*             serialized segment-wide stream (registered)
//   seg_idx            lane currently being served
//   null_drop_count    saturating count of dropped null segments
module axis_seg_serializer_ctrl #(
  parameter int AXIS_BUS_WIDTH  = 64,
  parameter int AXIS_USER_WIDTH = 4,
  parameter int NUM_SEGMENTS    = 4,
  parameter int DROP_CNT_WIDTH  = 16,
  localparam int AXIS_SEG_WIDTH = AXIS_BUS_WIDTH / NUM_SEGMENTS,
  localparam int NUM_SEG_BYTES  = AXIS_SEG_WIDTH / 8,
  localparam int IDX_WIDTH      = $clog2(NUM_SEGMENTS)
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXIS_SEG_WIDTH-1:0]  seg_in_tdata [NUM_SEGMENTS],
  input  logic [NUM_SEG_BYTES-1:0]   seg_in_tkeep [NUM_SEGMENTS],
  input  logic [AXIS_USER_WIDTH-1:0] seg_in_tuser,
  input  logic                       seg_in_tlast,
  input  logic [NUM_SEGMENTS-1:0]    seg_in_tvalid,
  output logic [NUM_SEGMENTS-1:0]    seg_in_tready,
  output logic [AXIS_SEG_WIDTH-1:0]  out_tdata,
  output logic [NUM_SEG_BYTES-1:0]   out_tkeep,
  output logic [AXIS_USER_WIDTH-1:0] out_tuser,
  output logic                       out_tlast,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic [IDX_WIDTH-1:0]       seg_idx,
  output logic [DROP_CNT_WIDTH-1:0]  null_drop_count
);

  localparam logic [IDX_WIDTH-1:0] LAST_LANE = IDX_WIDTH'(NUM_SEGMENTS - 1);

  logic [IDX_WIDTH-1:0] last_idx;
  logic                 cur_is_last;
  logic                 emit;
  logic                 out_load;
  logic                 pop;

  // Highest lane holding data. An all-null beat falls back to the final lane so that a
  // tlast-only beat still produces one (empty) segment and the packet boundary survives.
  always_comb begin
    last_idx = LAST_LANE;
    for (int j = 0; j < NUM_SEGMENTS; j++) begin
      if (|seg_in_tkeep[j]) begin
        last_idx = IDX_WIDTH'(j);
      end
    end
  end

  assign cur_is_last = (seg_idx == last_idx);
  assign emit        = (|seg_in_tkeep[seg_idx]) || (seg_in_tlast && cur_is_last);
  assign out_load    = ~out_tvalid | out_tready;
  // Null segments never need the output register, so they drain even under backpressure.
  assign pop         = seg_in_tvalid[seg_idx] & (~emit | out_load);

  always_comb begin
    seg_in_tready          = '0;
    seg_in_tready[seg_idx] = pop;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      seg_idx         <= '0;
      out_tvalid      <= 1'b0;
      out_tdata       <= '0;
      out_tkeep       <= '0;
      out_tuser       <= '0;
      out_tlast       <= 1'b0;
      null_drop_count <= '0;
    end else begin
      if (pop) begin
        seg_idx <= (seg_idx == LAST_LANE) ? '0 : seg_idx + 1'b1;
      end

      // A load in the same cycle as a consume overwrites the register and keeps valid high.
      if (pop && emit) begin
        out_tdata  <= seg_in_tdata[seg_idx];
        out_tkeep  <= seg_in_tkeep[seg_idx];
        out_tuser  <= seg_in_tuser;
        out_tlast  <= seg_in_tlast && cur_is_last;
        out_tvalid <= 1'b1;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
      end

      if (pop && !emit && !(&null_drop_count)) begin
        null_drop_count <= null_drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_axis_seg_serializer_ctrl.sv
`timescale 1ns/1ps
module tb_axis_seg_serializer_ctrl;
  localparam int BW   = 64;
  localparam int UW   = 4;
  localparam int NS   = 4;
  localparam int DW   = 8;
  localparam int SW   = BW / NS;
  localparam int NB   = SW / 8;
  localparam int IW   = $clog2(NS);
  localparam int DMAX = (1 << DW) - 1;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [SW-1:0] seg_in_tdata [NS];
  logic [NB-1:0] seg_in_tkeep [NS];
  logic [UW-1:0] seg_in_tuser;
  logic          seg_in_tlast;
  logic [NS-1:0] seg_in_tvalid;
  logic [NS-1:0] seg_in_tready;
  logic [SW-1:0] out_tdata;
  logic [NB-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;
  logic          out_tlast;
  logic          out_tvalid;
  logic          out_tready;
  logic [IW-1:0] seg_idx;
  logic [DW-1:0] null_drop_count;

  always #5 aclk = ~aclk;

  axis_seg_serializer_ctrl #(
    .AXIS_BUS_WIDTH(BW), .AXIS_USER_WIDTH(UW), .NUM_SEGMENTS(NS), .DROP_CNT_WIDTH(DW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .seg_in_tdata(seg_in_tdata), .seg_in_tkeep(seg_in_tkeep), .seg_in_tuser(seg_in_tuser),
    .seg_in_tlast(seg_in_tlast), .seg_in_tvalid(seg_in_tvalid), .seg_in_tready(seg_in_tready),
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tuser(out_tuser), .out_tlast(out_tlast),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .seg_idx(seg_idx), .null_drop_count(null_drop_count)
  );

  typedef struct packed {
    logic [NS-1:0][SW-1:0] d;
    logic [NS-1:0][NB-1:0] k;
    logic [UW-1:0]         u;
    logic                  l;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] d;
    logic [NB-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } seg_t;

  // Directed vector: beat keep (lane 0 in the low bits), tlast, which lanes must come out,
  // which lane carries tlast (F = none) and how many segments are dropped.
  typedef struct packed {
    logic [NS-1:0][NB-1:0] keep;
    logic                  tlast;
    logic [NS-1:0]         exp_mask;
    logic [3:0]            exp_last;
    logic [3:0]            exp_drops;
  } vec_t;

  int    total = 0;
  int    bad   = 0;
  int    exp_drops = 0;
  beat_t cur;
  logic [NS-1:0] pend;
  beat_t src_q[$];
  seg_t  exp_q[$];
  seg_t  act_q[$];
  vec_t  tbl [9];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, a, e, $time);
    end
  endtask

  function automatic int sat_add(input int a, input int b);
    return (a + b > DMAX) ? DMAX : a + b;
  endfunction

  // Reference: what a beat must turn into, straight from the serialization rules.
  function automatic void model_beat(input beat_t b);
    int   last;
    seg_t s;
    last = NS - 1;
    for (int j = NS - 1; j >= 0; j--) begin
      if (b.k[j] != '0) begin
        last = j;
        break;
      end
    end
    for (int j = 0; j < NS; j++) begin
      if (b.k[j] != '0 || (b.l && j == last)) begin
        s.d = b.d[j]; s.k = b.k[j]; s.u = b.u; s.l = b.l && (j == last);
        exp_q.push_back(s);
      end else begin
        exp_drops = sat_add(exp_drops, 1);
      end
    end
  endfunction

  function automatic beat_t mk_beat(input logic [NS-1:0][NB-1:0] k, input logic l, input int id);
    beat_t b;
    for (int j = 0; j < NS; j++) b.d[j] = SW'((id << 8) | j);
    b.k = k;
    b.u = UW'(id);
    b.l = l;
    return b;
  endfunction

  function automatic beat_t rand_beat(input int null_pct);
    beat_t b;
    for (int j = 0; j < NS; j++) begin
      b.d[j] = SW'($urandom);
      b.k[j] = (int'($urandom_range(99)) < null_pct) ? '0 : NB'($urandom_range((1 << NB) - 1, 1));
    end
    b.u = UW'($urandom);
    b.l = 1'($urandom_range(1));
    return b;
  endfunction

  task automatic apply_inputs(input logic [NS-1:0] stall);
    for (int j = 0; j < NS; j++) begin
      seg_in_tdata[j] = cur.d[j];
      seg_in_tkeep[j] = cur.k[j];
    end
    seg_in_tuser  = cur.u;
    seg_in_tlast  = cur.l;
    seg_in_tvalid = pend & ~stall;
  endtask

  // Plays src_q as a lane-FIFO source (a popped lane goes empty, the next beat appears once the
  // last lane pops), checks pop order/liveness and output stability, collects outputs in act_q.
  task automatic run_stream(input int rdy_pct, input int stall_pct, input int budget);
    int            nxt, cyc, pop_lane;
    bit            held_v, must;
    seg_t          held;
    logic [NS-1:0] stall;
    nxt = 0; cyc = 0; held_v = 0; held = '0; stall = '0; pend = '0;
    @(posedge aclk); #1;
    if (src_q.size() > 0) begin cur = src_q.pop_front(); pend = '1; end
    out_tready = (int'($urandom_range(99)) < rdy_pct);
    apply_inputs(stall);
    while (cyc < budget) begin
      @(negedge aclk);
      if (held_v) begin
        chk("hold_vld", 64'(out_tvalid), 64'(1));
        chk("hold_dat", 64'({out_tdata, out_tkeep, out_tuser, out_tlast}), 64'(held));
      end
      held_v = 0;
      if (out_tvalid) begin
        if (out_tready) act_q.push_back(seg_t'({out_tdata, out_tkeep, out_tuser, out_tlast}));
        else begin held = seg_t'({out_tdata, out_tkeep, out_tuser, out_tlast}); held_v = 1; end
      end
      chk("seg_idx", 64'(seg_idx), 64'(nxt));
      must = seg_in_tvalid[nxt] && (!out_tvalid || out_tready);
      if (must) chk("pop_taken", 64'(seg_in_tready), 64'(1) << nxt);
      pop_lane = -1;
      if (seg_in_tready != '0) begin
        chk("pop_lane", 64'(seg_in_tready), 64'(1) << nxt);
        chk("pop_vld", 64'(seg_in_tvalid[nxt]), 64'(1));
        pop_lane = nxt;
        nxt = (nxt + 1) % NS;
      end
      @(posedge aclk); #1;
      cyc++;
      if (pop_lane >= 0) begin
        pend[pop_lane] = 1'b0;
        if (pop_lane == NS - 1 && src_q.size() > 0) begin cur = src_q.pop_front(); pend = '1; end
      end
      if (pend == '0 && src_q.size() == 0 && !out_tvalid) break;
      for (int j = 0; j < NS; j++) stall[j] = (int'($urandom_range(99)) < stall_pct);
      out_tready = (int'($urandom_range(99)) < rdy_pct);
      apply_inputs(stall);
    end
    chk("stream_done", 64'(cyc < budget), 64'(1));
    pend = '0;
    apply_inputs('0);
    out_tready = 1'b1;
  endtask

  task automatic compare_queues(input string tag);
    seg_t a, e;
    chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_seg"}, 64'(a), 64'(e));
    end
    act_q.delete();
    exp_q.delete();
    chk({tag, "_drops"}, 64'(null_drop_count), 64'(exp_drops));
  endtask

  task automatic random_run(input int nbeats, input int null_pct, input int rdy_pct,
                            input int stall_pct, input string tag);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b = rand_beat(null_pct);
      src_q.push_back(b);
      model_beat(b);
    end
    run_stream(rdy_pct, stall_pct, 4000);
    compare_queues(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    seg_t s;
    int   n;
    tbl[0] = '{8'hFF, 1'b1, 4'b1111, 4'd3,  4'd0};
    tbl[1] = '{8'h33, 1'b1, 4'b0101, 4'd2,  4'd2};
    tbl[2] = '{8'h00, 1'b1, 4'b1000, 4'd3,  4'd3};
    tbl[3] = '{8'h00, 1'b0, 4'b0000, 4'hF,  4'd4};
    tbl[4] = '{8'h01, 1'b0, 4'b0001, 4'hF,  4'd3};
    tbl[5] = '{8'h80, 1'b1, 4'b1000, 4'd3,  4'd3};
    tbl[6] = '{8'h04, 1'b1, 4'b0010, 4'd1,  4'd3};
    tbl[7] = '{8'hC2, 1'b0, 4'b1001, 4'hF,  4'd2};
    tbl[8] = '{8'h1C, 1'b1, 4'b0110, 4'd2,  4'd2};

    aresetn = 1'b0; out_tready = 1'b1; cur = '0; pend = '0;
    apply_inputs('0);
    #22;
    chk("rst_seg_idx", 64'(seg_idx), 64'(0));
    chk("rst_vld",     64'(out_tvalid), 64'(0));
    chk("rst_out",     64'({out_tdata, out_tkeep, out_tuser, out_tlast}), 64'(0));
    chk("rst_drops",   64'(null_drop_count), 64'(0));
    chk("rst_tready",  64'(seg_in_tready), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;

    // Full beat, full throughput: lanes 0..3 on consecutive cycles, tlast on the 4th.
    @(posedge aclk); #1;
    cur = mk_beat('1, 1'b1, 1); pend = '1; out_tready = 1'b1; apply_inputs('0);
    @(negedge aclk);
    chk("t1_pop0", 64'(seg_in_tready), 64'(1));
    chk("t1_vld0", 64'(out_tvalid), 64'(0));
    for (int k = 0; k < NS; k++) begin
      @(posedge aclk); #1;
      pend[k] = 1'b0; apply_inputs('0);
      @(negedge aclk);
      chk("t1_vld",  64'(out_tvalid), 64'(1));
      chk("t1_lane", 64'(out_tdata), 64'((1 << 8) | k));
      chk("t1_last", 64'(out_tlast), 64'(k == NS - 1));
      chk("t1_pop",  64'(seg_in_tready), (k < NS - 1) ? (64'(1) << (k + 1)) : 64'(0));
    end
    @(negedge aclk);
    chk("t1_idle", 64'(out_tvalid), 64'(0));
    chk("t1_idx",  64'(seg_idx), 64'(0));

    // Directed keep/tlast patterns.
    for (int i = 0; i < 9; i++) begin
      src_q.push_back(mk_beat(tbl[i].keep, tbl[i].tlast, i));
      run_stream(100, 0, 50);
      exp_drops = sat_add(exp_drops, int'(tbl[i].exp_drops));
      chk("tv_count", 64'(act_q.size()), 64'($countones(tbl[i].exp_mask)));
      n = 0;
      for (int j = 0; j < NS; j++) begin
        if (tbl[i].exp_mask[j]) begin
          if (n < act_q.size()) begin
            s = act_q[n];
            chk("tv_lane", 64'(s.d), 64'((i << 8) | j));
            chk("tv_keep", 64'(s.k), 64'(tbl[i].keep[j]));
            chk("tv_last", 64'(s.l), 64'(4'(j) == tbl[i].exp_last));
          end
          n++;
        end
      end
      act_q.delete();
      chk("tv_drops", 64'(null_drop_count), 64'(exp_drops));
    end

    // Output held off for 5 cycles after the first load.
    @(posedge aclk); #1;
    cur = mk_beat('1, 1'b1, 2); pend = '1; out_tready = 1'b0; apply_inputs('0);
    @(negedge aclk);
    chk("t4_pop0", 64'(seg_in_tready), 64'(1));
    @(posedge aclk); #1;
    pend[0] = 1'b0; apply_inputs('0);
    for (int c = 0; c < 5; c++) begin
      @(negedge aclk);
      chk("t4_hold_vld", 64'(out_tvalid), 64'(1));
      chk("t4_hold_dat", 64'({out_tdata, out_tlast}), 64'({SW'(2 << 8), 1'b0}));
      chk("t4_no_pop",   64'(seg_in_tready), 64'(0));
      @(posedge aclk); #1;
    end
    out_tready = 1'b1;
    for (int k = 0; k < NS; k++) begin
      @(negedge aclk);
      chk("t4_vld",  64'(out_tvalid), 64'(1));
      chk("t4_lane", 64'(out_tdata), 64'((2 << 8) | k));
      chk("t4_pop",  64'(seg_in_tready), (k < NS - 1) ? (64'(1) << (k + 1)) : 64'(0));
      @(posedge aclk); #1;
      if (k < NS - 1) pend[k + 1] = 1'b0;
      apply_inputs('0);
    end
    @(negedge aclk);
    chk("t4_idle", 64'(out_tvalid), 64'(0));

    // Lane 2 empty for 3 cycles mid-beat.
    @(posedge aclk); #1;
    cur = mk_beat('1, 1'b1, 3); pend = '1; apply_inputs(4'b0100);
    @(negedge aclk); chk("t5_pop0", 64'(seg_in_tready), 64'(4'b0001));
    @(posedge aclk); #1; pend[0] = 1'b0; apply_inputs(4'b0100);
    @(negedge aclk); chk("t5_pop1", 64'(seg_in_tready), 64'(4'b0010));
    @(posedge aclk); #1; pend[1] = 1'b0; apply_inputs(4'b0100);
    for (int c = 0; c < 3; c++) begin
      @(negedge aclk);
      chk("t5_idx",    64'(seg_idx), 64'(2));
      chk("t5_no_pop", 64'(seg_in_tready), 64'(0));
      @(posedge aclk); #1;
    end
    apply_inputs('0);
    @(negedge aclk); chk("t5_pop2", 64'(seg_in_tready), 64'(4'b0100));
    @(posedge aclk); #1; pend[2] = 1'b0; apply_inputs('0);
    @(negedge aclk); chk("t5_pop3", 64'(seg_in_tready), 64'(4'b1000));
    @(posedge aclk); #1; pend[3] = 1'b0; apply_inputs('0);
    @(negedge aclk);
    chk("t5_last", 64'({out_tvalid, out_tdata, out_tlast}), 64'({1'b1, SW'((3 << 8) | 3), 1'b1}));
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("t5_idle", 64'({out_tvalid, seg_idx}), 64'(0));

    // Randomized traffic against the reference model.
    random_run(40, 40, 100, 0,  "rnd_a");
    random_run(40, 40, 70,  20, "rnd_b");
    random_run(40, 40, 40,  40, "rnd_c");
    random_run(30, 90, 60,  10, "rnd_nulls");

    // Reset in the middle of a beat: seg_idx=2 with a segment waiting at the output.
    @(posedge aclk); #1;
    cur = mk_beat('1, 1'b1, 5); pend = '1; out_tready = 1'b1; apply_inputs(4'b0100);
    @(posedge aclk); #1; pend[0] = 1'b0; apply_inputs(4'b0100);
    @(posedge aclk); #1; pend[1] = 1'b0; apply_inputs(4'b0100);
    out_tready = 1'b0;
    chk("t6_pre_idx", 64'(seg_idx), 64'(2));
    chk("t6_pre_vld", 64'(out_tvalid), 64'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk("t6_vld",    64'(out_tvalid), 64'(0));
    chk("t6_idx",    64'(seg_idx), 64'(0));
    chk("t6_out",    64'({out_tdata, out_tkeep, out_tlast}), 64'(0));
    chk("t6_drops",  64'(null_drop_count), 64'(0));
    exp_drops = 0;
    pend = '0; apply_inputs('0); out_tready = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;

    // Drop counter saturation: 60 all-null beats then 10 more (240 -> clamp at max).
    for (int i = 0; i < 60; i++) begin
      src_q.push_back(mk_beat('0, 1'b0, i));
      model_beat(mk_beat('0, 1'b0, i));
    end
    run_stream(100, 0, 1000);
    compare_queues("sat_240");
    for (int i = 0; i < 10; i++) begin
      src_q.push_back(mk_beat('0, 1'b0, i));
      model_beat(mk_beat('0, 1'b0, i));
    end
    run_stream(100, 0, 1000);
    compare_queues("sat_max");
    chk("sat_value", 64'(null_drop_count), 64'(DMAX));
    random_run(20, 50, 80, 10, "rnd_post_sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
